// File: rtl/calc_cmd_issuer_if.sv
// rtl/calc_cmd_issuer_if.sv - host command/result and calculator handshake bundle for calc_cmd_issuer
interface calc_cmd_issuer_if #(
  parameter int W     = 4,
  parameter int DEPTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [W-1:0]             cmd_a;
  logic [W-1:0]             cmd_b;
  logic                     calc_go;
  logic [1:0]               calc_op;
  logic [W-1:0]             calc_in1;
  logic [W-1:0]             calc_in2;
  logic                     calc_done;
  logic [W-1:0]             calc_result;
  logic                     res_valid;
  logic                     res_ready;
  logic [W-1:0]             res_data;
  logic [1:0]               res_op;
  logic                     res_err;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, calc_done, calc_result, res_ready,
    output cmd_ready, calc_go, calc_op, calc_in1, calc_in2,
           res_valid, res_data, res_op, res_err, busy, fifo_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, calc_done, calc_result, res_ready,
    input  cmd_ready, calc_go, calc_op, calc_in1, calc_in2,
           res_valid, res_data, res_op, res_err, busy, fifo_count
  );
endinterface

// File: rtl/calc_cmd_issuer.sv
// rtl/calc_cmd_issuer.sv - command FIFO and go/done issuer for the calculator core
// Optional WAIT timeout enabled by defining CALC_TIMEOUT_EN.
module calc_cmd_issuer #(
  parameter int W       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  calc_cmd_issuer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + 2 * W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("calc_cmd_issuer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  logic           calc_go_q;
  logic [1:0]     calc_op_q;
  logic [W-1:0]   calc_in1_q;
  logic [W-1:0]   calc_in2_q;
  logic           res_valid_q;
  logic [W-1:0]   res_data_q;
  logic [1:0]     res_op_q;

  // Popping only when the result slot is free (or freeing now) means done can always be captured.
  assign bus.cmd_ready  = (count < CW'(DEPTH));
  assign push           = bus.cmd_valid & bus.cmd_ready;
  assign pop            = (state == IDLE) & (count != '0) & (!res_valid_q | bus.res_ready);

  assign bus.calc_go    = calc_go_q;
  assign bus.calc_op    = calc_op_q;
  assign bus.calc_in1   = calc_in1_q;
  assign bus.calc_in2   = calc_in2_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_op     = res_op_q;
  assign bus.busy       = (state != IDLE) | (count != '0) | res_valid_q;
  assign bus.fifo_count = count;

`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  wait_cnt;
  logic           res_err_q;
  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      calc_go_q   <= 1'b0;
      calc_op_q   <= '0;
      calc_in1_q  <= '0;
      calc_in2_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
`ifdef CALC_TIMEOUT_EN
      wait_cnt    <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            {calc_op_q, calc_in1_q, calc_in2_q} <= mem[rd_ptr];
            calc_go_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          calc_go_q <= 1'b0;
`ifdef CALC_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.calc_done) begin
            res_data_q  <= bus.calc_result;
            res_op_q    <= calc_op_q;
            res_valid_q <= 1'b1;
`ifdef CALC_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
            state       <= IDLE;
          end
`ifdef CALC_TIMEOUT_EN
          // A done arriving after the timeout lands in IDLE and is dropped there.
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            res_data_q  <= '0;
            res_op_q    <= calc_op_q;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          calc_go_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_cmd_issuer.sv
// tb/tb_calc_cmd_issuer.sv - directed self-checking bench for calc_cmd_issuer
module tb_calc_cmd_issuer;
  localparam int W     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  calc_cmd_issuer_if #(.W(W), .DEPTH(DEPTH)) bus ();

  calc_cmd_issuer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Calculator model: go -> states 1,2,3,op,final(done); stall freezes before final, drop ignores go.
  logic [2:0] mcnt;
  logic       stall;
  logic       drop;
  logic       spur;

  always @(posedge clk) begin
    if (rst) mcnt <= 3'd0;
    else if (mcnt == 3'd0) begin
      if (bus.calc_go && !drop) mcnt <= 3'd1;
    end else if (mcnt == 3'd5) mcnt <= 3'd0;
    else if (!stall) mcnt <= mcnt + 3'd1;
  end

  assign bus.calc_done = (mcnt == 3'd5) | spur;
  assign bus.calc_result = (bus.calc_op == 2'b00) ? (bus.calc_in1 & bus.calc_in2) :
                           (bus.calc_op == 2'b01) ? (bus.calc_in1 + bus.calc_in2) :
                           (bus.calc_op == 2'b10) ? (bus.calc_in1 - bus.calc_in2) :
                                                    (bus.calc_in1 ^ bus.calc_in2);

  logic [6:0] got_q [$];

  always @(negedge clk) begin
    #2;
    if (!rst && bus.res_valid && bus.res_ready) got_q.push_back({bus.res_err, bus.res_op, bus.res_data});
  end

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !bus.cmd_ready; i++) @(negedge clk);
    checks++;
    if (!bus.cmd_ready) begin failures++; $display("FAIL push_timeout cmd_ready=%b required=1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.calc_go, bus.calc_op, bus.calc_in1, bus.calc_in2} !== {1'b1, 1'b0, 2'd0, 4'd0, 4'd0}) begin
      failures++; $display("FAIL reset_calc got=%b required=%b", {bus.cmd_ready, bus.calc_go, bus.calc_op, bus.calc_in1, bus.calc_in2}, 12'b1000_0000_0000);
    end
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_op, bus.res_err, bus.busy, bus.fifo_count} !== 12'd0) begin
      failures++; $display("FAIL reset_res got=%b required=0", {bus.res_valid, bus.res_data, bus.res_op, bus.res_err, bus.busy, bus.fifo_count});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.calc_go} !== 2'b00) begin failures++; $display("FAIL reset_release busy_go=%b required=00", {bus.busy, bus.calc_go}); end
  endtask

  task automatic test_single();
    got_q.delete(); bus.res_ready = 1'b0;
    push(2'b01, 4'd3, 4'd5);
    checks++;
    if ({bus.calc_go, bus.fifo_count} !== {1'b0, 3'd1}) begin
      failures++; $display("FAIL single_t1 go_count=%b required=%b", {bus.calc_go, bus.fifo_count}, 4'b0001);
    end
    @(negedge clk);
    checks++;
    if ({bus.calc_go, bus.calc_op, bus.calc_in1, bus.calc_in2, bus.fifo_count} !== {1'b1, 2'b01, 4'd3, 4'd5, 3'd0}) begin
      failures++; $display("FAIL single_t2 got=%b required=%b", {bus.calc_go, bus.calc_op, bus.calc_in1, bus.calc_in2, bus.fifo_count}, {1'b1, 2'b01, 4'd3, 4'd5, 3'd0});
    end
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.calc_go, bus.res_valid, bus.calc_in1, bus.calc_in2} !== {1'b0, 1'b0, 4'd3, 4'd5}) begin
        failures++; $display("FAIL single_wait_t%0d go_rv_in1_in2=%b required=%b", k, {bus.calc_go, bus.res_valid, bus.calc_in1, bus.calc_in2}, {2'b00, 4'd3, 4'd5});
      end
    end
    for (int k = 8; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.res_data, bus.res_op, bus.res_err} !== {1'b1, 4'd8, 2'b01, 1'b0}) begin
        failures++; $display("FAIL single_result_t%0d got=%b required=%b", k, {bus.res_valid, bus.res_data, bus.res_op, bus.res_err}, {1'b1, 4'd8, 2'b01, 1'b0});
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00 || got_q.size() != 1) begin
      failures++; $display("FAIL single_drain rv_busy=%b logged=%0d required=00/1", {bus.res_valid, bus.busy}, got_q.size());
    end
  endtask

  task automatic test_fill_order();
    logic [1:0] ops [6];
    logic [3:0] av [6];
    logic [3:0] bv [6];
    logic [3:0] ev [6];
    ops = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    av  = '{4'd3, 4'd4, 4'd9, 4'd12, 4'd15, 4'd1};
    bv  = '{4'd5, 4'd6, 4'd2, 4'd10, 4'd1, 4'd2};
    ev  = '{4'd1, 4'd10, 4'd7, 4'd6, 4'd0, 4'd15};
    got_q.delete(); bus.res_ready = 1'b1; stall = 1'b1;
    for (int i = 0; i < 5; i++) push(ops[i], av[i], bv[i]);
    checks++;
    if ({bus.fifo_count, bus.cmd_ready} !== {3'd4, 1'b0}) begin
      failures++; $display("FAIL fill_full count_ready=%b required=%b", {bus.fifo_count, bus.cmd_ready}, {3'd4, 1'b0});
    end
    bus.cmd_op = ops[5]; bus.cmd_a = av[5]; bus.cmd_b = bv[5]; bus.cmd_valid = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({bus.fifo_count, bus.cmd_ready, bus.res_valid} !== {3'd4, 1'b0, 1'b0}) begin
      failures++; $display("FAIL fill_held count_ready_rv=%b required=%b", {bus.fifo_count, bus.cmd_ready, bus.res_valid}, {3'd4, 2'b00});
    end
    stall = 1'b0;
    push(ops[5], av[5], bv[5]);
    for (int i = 0; i < 300 && got_q.size() < 6; i++) @(negedge clk);
    checks++;
    if (got_q.size() != 6) begin failures++; $display("FAIL fill_count results=%0d required=6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== {1'b0, ops[i], ev[i]}) begin
        failures++; $display("FAIL fill_order_%0d got=%b required=%b", i, (got_q.size() > i) ? got_q[i] : 7'bx, {1'b0, ops[i], ev[i]});
      end
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [6:0] exp_r [3];
    exp_r = '{{1'b0, 2'b01, 4'd8}, {1'b0, 2'b11, 4'd6}, {1'b0, 2'b00, 4'd4}};
    got_q.delete(); bus.res_ready = 1'b0;
    push(2'b01, 4'd3, 4'd5);
    push(2'b11, 4'd5, 4'd3);
    push(2'b00, 4'd7, 4'd12);
    for (int i = 0; i < 100 && !bus.res_valid; i++) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.calc_go, bus.res_valid, bus.res_data, bus.res_op, bus.fifo_count} !== {1'b0, 1'b1, 4'd8, 2'b01, 3'd2}) begin
        failures++; $display("FAIL bp_hold_%0d got=%b required=%b", k, {bus.calc_go, bus.res_valid, bus.res_data, bus.res_op, bus.fifo_count}, {2'b01, 4'd8, 2'b01, 3'd2});
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.calc_go, bus.res_valid, bus.fifo_count} !== {1'b1, 1'b0, 3'd1}) begin
      failures++; $display("FAIL bp_go_after_pop got=%b required=%b", {bus.calc_go, bus.res_valid, bus.fifo_count}, {2'b10, 3'd1});
    end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 3; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_r[i]) begin
        failures++; $display("FAIL bp_result_%0d got=%b required=%b", i, (got_q.size() > i) ? got_q[i] : 7'bx, exp_r[i]);
      end
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    got_q.delete(); bus.res_ready = 1'b1; stall = 1'b1;
    push(2'b01, 4'd1, 4'd1);
    push(2'b10, 4'd5, 4'd4);
    push(2'b11, 4'd6, 4'd6);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.fifo_count, bus.calc_go, bus.res_valid, bus.busy} !== {3'd2, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rstmid_pre got=%b required=%b", {bus.fifo_count, bus.calc_go, bus.res_valid, bus.busy}, {3'd2, 3'b001});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.fifo_count, bus.res_valid, bus.calc_go, bus.busy, bus.calc_op, bus.calc_in1, bus.calc_in2} !== 16'd0) begin
      failures++; $display("FAIL rstmid_post got=%b required=0", {bus.fifo_count, bus.res_valid, bus.calc_go, bus.busy, bus.calc_op, bus.calc_in1, bus.calc_in2});
    end
    stall = 1'b0;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00 || got_q.size() != 0) begin
      failures++; $display("FAIL rstmid_late_done rv_busy=%b results=%0d required=00/0", {bus.res_valid, bus.busy}, got_q.size());
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_spurious_done();
    got_q.delete(); bus.res_ready = 1'b1;
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.res_valid, bus.busy, bus.calc_go} !== 3'b000) begin
        failures++; $display("FAIL spurious_%0d rv_busy_go=%b required=000", k, {bus.res_valid, bus.busy, bus.calc_go});
      end
    end
    spur = 1'b0;
    @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL spurious_results got=%0d required=0", got_q.size()); end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    got_q.delete(); bus.res_ready = 1'b0; drop = 1'b1;
    push(2'b01, 4'd2, 4'd3);
    @(negedge clk);
    checks++;
    if (bus.calc_go !== 1'b1) begin failures++; $display("FAIL timeout_go got=%b required=1", bus.calc_go); end
    bus.cmd_op = 2'b00; bus.cmd_a = 4'd15; bus.cmd_b = 4'd7; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL timeout_early rv=%b required=0", bus.res_valid); end
`ifdef CALC_TIMEOUT_EN
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_err, bus.res_data, bus.res_op} !== {1'b1, 1'b1, 4'd0, 2'b01}) begin
      failures++; $display("FAIL timeout_result got=%b required=%b", {bus.res_valid, bus.res_err, bus.res_data, bus.res_op}, {2'b11, 4'd0, 2'b01});
    end
    drop = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== {1'b1, 2'b01, 4'd0} || got_q[1] !== {1'b0, 2'b00, 4'd7}) begin
      failures++; $display("FAIL timeout_followup results=%0d required=2 (err/01/0 then ok/00/7)", got_q.size());
    end
    bus.res_ready = 1'b0;
`else
    repeat (24) @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.busy, bus.calc_go, bus.calc_in1, bus.calc_in2, bus.fifo_count, bus.res_err} !== {3'b010, 4'd2, 4'd3, 3'd1, 1'b0}) begin
      failures++; $display("FAIL timeout_waits got=%b required=%b", {bus.res_valid, bus.busy, bus.calc_go, bus.calc_in1, bus.calc_in2, bus.fifo_count, bus.res_err}, {3'b010, 4'd2, 4'd3, 3'd1, 1'b0});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drop = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL timeout_cleanup busy=%b required=0", bus.busy); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = '0; bus.cmd_b = '0; bus.res_ready = 1'b0;
    stall = 1'b0; drop = 1'b0; spur = 1'b0;
    test_reset();
    test_single();
    test_fill_order();
    test_backpressure();
    test_reset_mid();
    test_spurious_done();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
